demux_l2: RTL and testbench

DEMUX_L2 -- requirements
Module: demux_l2

---
 rtl/demux_l2_pkg.sv | 14 +
 rtl/demux_l2_lane_fifo.sv | 92 +++++++++
 rtl/demux_l2.sv | 75 +++++++
 tb/tb_demux_l2.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/demux_l2_pkg.sv
// demux_l2_pkg: shared width/depth defaults and lane index constants.
// Rev 1.0
`default_nettype none

package demux_l2_pkg;

  localparam int  DEF_WIDTH = 8;
  localparam int  DEF_DEPTH = 4;
  localparam logic LANE0    = 1'b0;
  localparam logic LANE1    = 1'b1;

endpackage : demux_l2_pkg

`default_nettype wire

// File: rtl/demux_l2_lane_fifo.sv
// lane_fifo: per-lane FIFO with registered, zero-when-idle read port and sticky overflow.
// Rev 1.0
`default_nettype none

module lane_fifo
  import demux_l2_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overflow_o
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             do_pop, do_push;

  assign full_o     = (count_q == CNT_FULL);
  assign empty_o    = (count_q == '0);
  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign overflow_o = ovf_q;

  // A pop frees a slot in the same cycle, so a full lane can still accept a push.
  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    data_d   = '0;
    valid_d  = do_pop;
    ovf_d    = ovf_q || (push_i && !do_push);
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      data_d   = mem_q[rd_ptr_q];
    end
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; the pointers alone define what is live.
  always_ff @(posedge clk) begin
    if (rst_ni && do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule : lane_fifo

`default_nettype wire

// File: rtl/demux_l2.sv
// demux_l2: splits an interleaved byte stream into two independent lane FIFOs.
// Rev 1.0
`default_nettype none

module demux_l2
  import demux_l2_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop0,
  input  logic             pop1,
  output logic             lane_sel,
  output logic [WIDTH-1:0] data_out0,
  output logic [WIDTH-1:0] data_out1,
  output logic             valid_out0,
  output logic             valid_out1,
  output logic             full0,
  output logic             full1,
  output logic             empty0,
  output logic             empty1,
  output logic             overflow0,
  output logic             overflow1
);

  logic lane_sel_q, lane_sel_d;
  logic push0, push1;

  // Lane ownership alternates every cycle whether or not the slot carries data.
  assign lane_sel_d = ~lane_sel_q;
  assign lane_sel   = lane_sel_q;
  assign push0      = valid_in && (lane_sel_q == LANE0);
  assign push1      = valid_in && (lane_sel_q == LANE1);

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      lane_sel_q <= LANE0;
    end else begin
      lane_sel_q <= lane_sel_d;
    end
  end

  lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane0 (
    .clk        (clk),
    .rst_ni     (reset_L),
    .push_i     (push0),
    .pop_i      (pop0),
    .data_i     (data_in),
    .data_o     (data_out0),
    .valid_o    (valid_out0),
    .full_o     (full0),
    .empty_o    (empty0),
    .overflow_o (overflow0)
  );

  lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane1 (
    .clk        (clk),
    .rst_ni     (reset_L),
    .push_i     (push1),
    .pop_i      (pop1),
    .data_i     (data_in),
    .data_o     (data_out1),
    .valid_o    (valid_out1),
    .full_o     (full1),
    .empty_o    (empty1),
    .overflow_o (overflow1)
  );

endmodule : demux_l2

`default_nettype wire

// File: tb/tb_demux_l2.sv
// tb_demux_l2: directed and random stimulus against a queue-based reference model.
// Rev 1.0
`default_nettype none

module tb_demux_l2;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       valid_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       pop0 = 1'b0;
  logic       pop1 = 1'b0;
  logic       lane_sel;
  logic [7:0] data_out0, data_out1;
  logic       valid_out0, valid_out1;
  logic       full0, full1, empty0, empty1, overflow0, overflow1;

  int total = 0;
  int bad   = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       m_sel;
  logic [7:0] m_d0, m_d1;
  logic       m_v0, m_v1, m_ovf0, m_ovf1;

  always #5 clk = ~clk;

  demux_l2 #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .pop0       (pop0),
    .pop1       (pop1),
    .lane_sel   (lane_sel),
    .data_out0  (data_out0),
    .data_out1  (data_out1),
    .valid_out0 (valid_out0),
    .valid_out1 (valid_out1),
    .full0      (full0),
    .full1      (full1),
    .empty0     (empty0),
    .empty1     (empty1),
    .overflow0  (overflow0),
    .overflow1  (overflow1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one clock edge, from the lane rules directly.
  task automatic model_edge(input logic rst_n, input logic v, input logic [7:0] d,
                            input logic p0, input logic p1);
    logic lane;
    if (!rst_n) begin
      q0.delete(); q1.delete();
      m_sel = 1'b0; m_d0 = 8'h00; m_d1 = 8'h00;
      m_v0 = 1'b0; m_v1 = 1'b0; m_ovf0 = 1'b0; m_ovf1 = 1'b0;
    end else begin
      lane = m_sel;
      m_v0 = 1'b0; m_d0 = 8'h00;
      m_v1 = 1'b0; m_d1 = 8'h00;
      if (p0 && q0.size() > 0) begin m_v0 = 1'b1; m_d0 = q0.pop_front(); end
      if (p1 && q1.size() > 0) begin m_v1 = 1'b1; m_d1 = q1.pop_front(); end
      if (v && lane == 1'b0) begin
        if (q0.size() < DEPTH) q0.push_back(d); else m_ovf0 = 1'b1;
      end
      if (v && lane == 1'b1) begin
        if (q1.size() < DEPTH) q1.push_back(d); else m_ovf1 = 1'b1;
      end
      m_sel = ~m_sel;
    end
  endtask

  task automatic compare_all();
    check("lane_sel",   {31'd0, lane_sel},   {31'd0, m_sel});
    check("data_out0",  {24'd0, data_out0},  {24'd0, m_d0});
    check("valid_out0", {31'd0, valid_out0}, {31'd0, m_v0});
    check("data_out1",  {24'd0, data_out1},  {24'd0, m_d1});
    check("valid_out1", {31'd0, valid_out1}, {31'd0, m_v1});
    check("full0",      {31'd0, full0},      {31'd0, (q0.size() == DEPTH)});
    check("full1",      {31'd0, full1},      {31'd0, (q1.size() == DEPTH)});
    check("empty0",     {31'd0, empty0},     {31'd0, (q0.size() == 0)});
    check("empty1",     {31'd0, empty1},     {31'd0, (q1.size() == 0)});
    check("overflow0",  {31'd0, overflow0},  {31'd0, m_ovf0});
    check("overflow1",  {31'd0, overflow1},  {31'd0, m_ovf1});
  endtask

  task automatic step(input logic rst_n, input logic v, input logic [7:0] d,
                      input logic p0, input logic p1);
    reset_L = rst_n; valid_in = v; data_in = d; pop0 = p0; pop1 = p1;
    @(posedge clk);
    model_edge(rst_n, v, d, p0, p1);
    #1;
    compare_all();
  endtask

  initial begin
    // Reset and interleaved fill of both lanes
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_empty0", {31'd0, empty0}, 32'd1);
    check("rst_sel",    {31'd0, lane_sel}, 32'd0);
    step(1'b1, 1'b1, 8'hA0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'hB0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'hB1, 1'b0, 1'b0);
    check("fill_empty1", {31'd0, empty1}, 32'd0);

    // Drain lane 0
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    check("pop_a0", {23'd0, valid_out0, data_out0}, {23'd0, 1'b1, 8'hA0});
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    check("pop_a1", {23'd0, valid_out0, data_out0}, {23'd0, 1'b1, 8'hA1});
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check("idle_d0", {23'd0, valid_out0, data_out0}, 32'd0);

    // Overflow on lane 0: five pushes, last one dropped
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    end
    check("ovf_set", {31'd0, overflow0}, 32'd1);
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("ovf_sticky", {31'd0, overflow0}, 32'd1);

    // Push and pop together on a full lane 0
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    end
    step(1'b1, 1'b1, 8'h10, 1'b1, 1'b0);
    check("full_pp", {22'd0, overflow0, full0, valid_out0, data_out0}, {22'd0, 1'b0, 1'b1, 1'b1, 8'h21});

    // Pop on empty lane 1, plus simultaneous push/pop on empty lane 1
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check("pop1_empty", {22'd0, empty1, valid_out1, data_out1}, {22'd0, 1'b1, 1'b0, 8'h00});
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h77, 1'b0, 1'b1);
    check("empty_pp", {22'd0, empty1, valid_out1, data_out1}, {22'd0, 1'b0, 1'b0, 8'h00});

    // Mid-operation reset with a concurrent pop
    step(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h66, 1'b1, 1'b1);
    check("mid_rst", {26'd0, lane_sel, valid_out0, valid_out1, empty0, empty1, full0},
                     {26'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    end

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 9) < 7), 8'($urandom),
           ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_demux_l2

`default_nettype wire
